// File: rtl/conv_8x32_loader.sv
// Front-end loader for the 8x32 convolution core: takes a size config, fills the X and Y
// operand memories from a byte stream, starts the core and serves its read ports.
module conv_8x32_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid_i,
    input  logic [ADDR_W-1:0]     cfg_sizeX_i,
    input  logic [ADDR_W-1:0]     cfg_sizeY_i,
    output logic                  cfg_ready_o,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    input  logic                  conv_busy_i,
    input  logic                  conv_done_i,
    output logic                  start_o,
    output logic [ADDR_W-1:0]     sizeX_o,
    output logic [ADDR_W-1:0]     sizeY_o,
    input  logic [ADDR_W-1:0]     memX_addr_i,
    input  logic [ADDR_W-1:0]     memY_addr_i,
    output logic [DATA_WIDTH-1:0] dataX_o,
    output logic [DATA_WIDTH-1:0] dataY_o,
    output logic                  loading_o,
    output logic                  err_o
);

    // state       | meaning
    // S_IDLE      | waiting for a config
    // S_LOAD_X    | writing stream bytes into memX
    // S_LOAD_Y    | writing stream bytes into memY
    // S_START     | one-cycle start pulse to the core
    // S_WAIT_BUSY | waiting for the core to go busy (stale done ignored)
    // S_WAIT_DONE | waiting for the core's done
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_Y,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]     r_sizeX;
    logic [ADDR_W-1:0]     r_sizeY;
    logic                  r_cfg_ready;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_memX [DEPTH];
    logic [DATA_WIDTH-1:0] r_memY [DEPTH];

    logic w_cfg_hs;
    logic w_cfg_legal;
    logic w_s_ready;
    logic w_s_hs;
    logic w_last;
    logic w_start;
    logic w_loading;

    assign w_cfg_hs    = cfg_valid_i && r_cfg_ready && (r_state == S_IDLE);
    assign w_cfg_legal = (cfg_sizeX_i != '0) && (cfg_sizeY_i != '0);
    assign w_s_hs      = s_valid_i && w_s_ready;
    assign w_last      = (r_state == S_LOAD_X) ? (r_cnt == r_sizeX - ADDR_W'(1))
                                               : (r_cnt == r_sizeY - ADDR_W'(1));

    always_comb begin
        w_next    = r_state;
        w_s_ready = 1'b0;
        w_start   = 1'b0;
        w_loading = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cfg_hs && w_cfg_legal) w_next = S_LOAD_X;
            end
            S_LOAD_X: begin
                w_s_ready = 1'b1;
                w_loading = 1'b1;
                if (s_valid_i && w_last) w_next = S_LOAD_Y;
            end
            S_LOAD_Y: begin
                w_s_ready = 1'b1;
                w_loading = 1'b1;
                if (s_valid_i && w_last) w_next = S_START;
            end
            S_START: begin
                w_start = 1'b1;
                w_next  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (conv_busy_i) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (conv_done_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // cfg_ready is registered so it stays low during the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sizeX     <= '0;
            r_sizeY     <= '0;
            r_cfg_ready <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cfg_ready <= (w_next == S_IDLE);
            r_err       <= w_cfg_hs && !w_cfg_legal;
            if (w_cfg_hs && w_cfg_legal) begin
                r_sizeX <= cfg_sizeX_i;
                r_sizeY <= cfg_sizeY_i;
                r_cnt   <= '0;
            end else if (w_s_hs) begin
                r_cnt <= w_last ? '0 : r_cnt + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_s_hs && (r_state == S_LOAD_X)) r_memX[r_cnt] <= s_data_i;
        if (!rst && w_s_hs && (r_state == S_LOAD_Y)) r_memY[r_cnt] <= s_data_i;
    end

    assign dataX_o     = (memX_addr_i < r_sizeX) ? r_memX[memX_addr_i] : '0;
    assign dataY_o     = (memY_addr_i < r_sizeY) ? r_memY[memY_addr_i] : '0;
    assign cfg_ready_o = r_cfg_ready;
    assign s_ready_o   = w_s_ready;
    assign start_o     = w_start;
    assign loading_o   = w_loading;
    assign err_o       = r_err;
    assign sizeX_o     = r_sizeX;
    assign sizeY_o     = r_sizeY;

endmodule
